// File: rtl/instruction_encoder.sv
// instruction_encoder: packs RV32 fields into instruction words behind a 2-entry output FIFO.
module instruction_encoder #(
  parameter int WIDTH_DATA = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [6:0]            opcode_i,
  input  logic [4:0]            rd_i,
  input  logic [4:0]            rs1_i,
  input  logic [4:0]            rs2_i,
  input  logic [2:0]            funct3_i,
  input  logic [6:0]            funct7_i,
  input  logic [WIDTH_DATA-1:0] imm_i,
  output logic [WIDTH_DATA-1:0] instr_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  err_o,
  output logic [1:0]            err_code_o,
  output logic [15:0]           count_o
);
  localparam logic [6:0] OP_R = 7'b0110011, OP_LD = 7'b0000011, OP_IMM = 7'b0010011,
                         OP_S = 7'b0100011, OP_B = 7'b1100011, OP_LUI = 7'b0110111,
                         OP_AUIPC = 7'b0010111, OP_J = 7'b1101111;
  logic [1:0]            occ;
  logic [WIDTH_DATA-1:0] head, tail, enc;
  logic [31:0]           word;
  logic [1:0]            err_code;
  logic [15:0]           count;
  logic                  accept, pop, push, supported, in_range, fits12, fits20;
  assign ready_o    = reset_n_i && (occ < 2'(FIFO_DEPTH));
  assign valid_o    = occ != 2'd0;
  assign instr_o    = head;
  assign err_code_o = err_code;
  assign err_o      = |err_code;
  assign count_o    = count;
  assign accept     = valid_i && ready_o;
  assign pop        = valid_o && ready_i;
  assign push       = accept && supported;
  assign enc        = WIDTH_DATA'(word);
  // A value fits N signed bits when everything from bit N-1 upward is a copy of the sign.
  assign fits12 = &imm_i[WIDTH_DATA-1:11] || ~|imm_i[WIDTH_DATA-1:11];
  assign fits20 = &imm_i[WIDTH_DATA-1:19] || ~|imm_i[WIDTH_DATA-1:19];
  always_comb begin
    word      = 32'd0;
    supported = 1'b1;
    in_range  = 1'b1;
    case (opcode_i)
      OP_R: word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      OP_LD, OP_IMM: begin
        word     = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        in_range = fits12;
      end
      OP_S: begin
        word     = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        in_range = fits12;
      end
      OP_B: begin
        word     = {imm_i[11], imm_i[9:4], rs2_i, rs1_i, funct3_i, imm_i[3:0], imm_i[10], opcode_i};
        in_range = fits12;
      end
      OP_LUI, OP_AUIPC: begin
        word     = {imm_i[19:0], rd_i, opcode_i};
        in_range = fits20;
      end
      OP_J: begin
        word     = {imm_i[19], imm_i[9:0], imm_i[10], imm_i[18:11], rd_i, opcode_i};
        in_range = fits20;
      end
      default: supported = 1'b0;
    endcase
  end
  // Head is always slot 0; a full buffer never pushes because ready_o is low.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      occ      <= 2'd0;
      head     <= '0;
      tail     <= '0;
      err_code <= 2'b00;
      count    <= 16'd0;
    end else begin
      if (pop) count <= count + 16'd1;
      if (accept) err_code <= err_code | {~supported, ~in_range};
      if (push && (occ == 2'd0 || (occ == 2'd1 && pop))) head <= enc;
      else if (pop) head <= tail;
      if (push && occ == 2'd1 && !pop) tail <= enc;
      occ <= occ + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: tb/tb_instruction_encoder.sv
// tb_instruction_encoder: scoreboard bench with a byte-offset ISA reference model.
module tb_instruction_encoder;
  logic        clk = 0, reset_n = 0, valid_i = 0, ready_i = 0;
  logic        ready_o, valid_o, err_o;
  logic [6:0]  opcode_i = 0, funct7_i = 0;
  logic [4:0]  rd_i = 0, rs1_i = 0, rs2_i = 0;
  logic [2:0]  funct3_i = 0;
  logic [31:0] imm_i = 0, instr_o;
  logic [1:0]  err_code_o;
  logic [15:0] count_o;
  int checks = 0, errors = 0, pops = 0;
  bit rand_rdy = 0;
  logic [31:0] sb[$];
  logic [6:0] ops[9] = '{7'h33, 7'h03, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h33};

  instruction_encoder dut (
    .clk_i(clk), .reset_n_i(reset_n), .valid_i(valid_i), .ready_o(ready_o),
    .opcode_i(opcode_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .funct3_i(funct3_i), .funct7_i(funct7_i), .imm_i(imm_i),
    .instr_o(instr_o), .valid_o(valid_o), .ready_i(ready_i),
    .err_o(err_o), .err_code_o(err_code_o), .count_o(count_o));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Standard ISA layouts, expressed on the byte offset (2*k) for branches and jumps.
  function automatic logic [31:0] model(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                                        input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] k);
    logic [31:0] off, o, d, s1, s2, f, r;
    off = k << 1;
    o = {25'd0, op}; d = {27'd0, rd} << 7; s1 = {27'd0, rs1} << 15;
    s2 = {27'd0, rs2} << 20; f = {29'd0, f3} << 12;
    case (op)
      7'h33: r = ({25'd0, f7} << 25) | s2 | s1 | f | d | o;
      7'h03, 7'h13: r = ((k & 32'hfff) << 20) | s1 | f | d | o;
      7'h23: r = (((k >> 5) & 32'h7f) << 25) | s2 | s1 | f | ((k & 32'h1f) << 7) | o;
      7'h63: r = (((off >> 12) & 1) << 31) | (((off >> 5) & 32'h3f) << 25) | s2 | s1 | f
                 | (((off >> 1) & 32'hf) << 8) | (((off >> 11) & 1) << 7) | o;
      7'h37, 7'h17: r = ((k & 32'hfffff) << 12) | d | o;
      7'h6f: r = (((off >> 20) & 1) << 31) | (((off >> 1) & 32'h3ff) << 21)
                 | (((off >> 11) & 1) << 20) | (((off >> 12) & 32'hff) << 12) | d | o;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
    if (rand_rdy) ready_i = $urandom_range(0, 3) != 0;
  endtask

  task automatic send(input logic [6:0] op, input logic [4:0] rd, rs1, rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] k, input bit push, input logic [31:0] exp);
    opcode_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2; funct3_i = f3; funct7_i = f7; imm_i = k;
    valid_i = 1;
    for (int t = 0; t < 200; t++) begin
      if (ready_o) begin
        if (push) sb.push_back(exp);
        tick();
        valid_i = 0;
        return;
      end
      tick();
    end
    valid_i = 0;
    chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 200; t++) begin
      if (sb.size() == 0 && !valid_o) return;
      tick();
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  // Monitor: a word is consumed at the next edge whenever valid_o && ready_i.
  initial forever begin
    @(negedge clk);
    if (valid_o && ready_i) begin
      chk("count_at_pop", {16'd0, count_o}, {16'd0, 16'(pops)});
      if (sb.size() == 0) chk("unexpected_word", instr_o, 32'hxxxxxxxx);
      else chk("instr", instr_o, sb.pop_front());
      pops++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] base;
    logic [31:0] k, w;
    logic [6:0] op;
    valid_i = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready_o, 0); chk("rst_valid", valid_o, 0); chk("rst_instr", instr_o, 0);
    chk("rst_err", {err_o, err_code_o}, 0); chk("rst_count", count_o, 0);
    valid_i = 0; reset_n = 1; ready_i = 1;
    #1 chk("ready_after_release", ready_o, 1);
    // Directed encodings
    send(7'h13, 1, 0, 0, 0, 0, 5, 1, 32'h00500093);
    chk("latency_valid", valid_o, 1);
    send(7'h23, 0, 1, 2, 3'b010, 0, 32'hfffffffc, 1, 32'hfe20ae23);
    send(7'h63, 0, 0, 0, 0, 0, 32'hfffffffc, 1, 32'hfe000ce3);
    send(7'h37, 5, 0, 0, 0, 0, 32'h12345, 1, 32'h123452b7);
    drain();
    // Backpressure
    base = count_o; ready_i = 0;
    send(7'h13, 1, 2, 0, 0, 0, 11, 1, model(7'h13, 1, 2, 0, 0, 0, 11));
    send(7'h13, 3, 4, 0, 0, 0, 22, 1, model(7'h13, 3, 4, 0, 0, 0, 22));
    chk("bp_ready_low", ready_o, 0);
    fork
      send(7'h13, 5, 6, 0, 0, 0, 33, 1, model(7'h13, 5, 6, 0, 0, 0, 33));
      begin
        repeat (3) begin @(posedge clk); #2 chk("bp_held", {ready_o, valid_i}, 2'b01); end
        ready_i = 1;
      end
    join
    drain();
    chk("bp_count", count_o - base, 3);
    // Random in-range traffic with random backpressure
    rand_rdy = 1;
    for (int i = 0; i < 250; i++) begin
      op = ops[$urandom_range(0, 8)];
      if (op == 7'h37 || op == 7'h17 || op == 7'h6f)
        k = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) != 0) ? 32'h7ffff : 32'hfff80000)
                                        : 32'($urandom_range(0, 1048575)) - 32'd524288;
      else
        k = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) != 0) ? 32'h7ff : 32'hfffff800)
                                        : 32'($urandom_range(0, 4095)) - 32'd2048;
      w = model(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), k);
      send(op, w[11:7], w[19:15], w[24:20], w[14:12], w[31:25], k, 1,
           model(op, w[11:7], w[19:15], w[24:20], w[14:12], w[31:25], k));
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_rdy = 0; ready_i = 1;
    drain();
    chk("no_err_in_range", {err_o, err_code_o}, 0);
    // Range and opcode errors
    send(7'h13, 1, 0, 0, 0, 0, 2048, 1, 32'h80000093);
    chk("err_range", {err_o, err_code_o}, 3'b101);
    send(7'h00, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("err_opcode", {err_o, err_code_o}, 3'b111);
    chk("bad_op_not_pushed", valid_o, 0);
    send(7'h37, 2, 0, 0, 0, 0, 7, 1, 32'h00007137);
    chk("err_sticky", {err_o, err_code_o}, 3'b111);
    drain();
    // Push and pop at occupancy 1 for 10 cycles
    base = count_o;
    for (int i = 0; i < 10; i++) begin
      k = 32'($urandom_range(0, 4095)) - 32'd2048;
      opcode_i = 7'h13; rd_i = 5'(i); rs1_i = 5'(i + 1); funct3_i = 0; imm_i = k; valid_i = 1;
      chk("stream_ready", ready_o, 1);
      sb.push_back(model(7'h13, 5'(i), 5'(i + 1), 0, 0, 0, k));
      @(posedge clk); #1;
      chk("stream_valid", valid_o, 1);
    end
    valid_i = 0;
    drain();
    chk("stream_count", count_o - base, 10);
    // Reset with a full buffer and errors set
    ready_i = 0;
    send(7'h37, 1, 0, 0, 0, 0, 1, 1, 0);
    send(7'h37, 2, 0, 0, 0, 0, 2, 1, 0);
    chk("full_before_reset", {valid_o, ready_o}, 2'b10);
    reset_n = 0;
    @(posedge clk); #1;
    sb.delete(); pops = 0;
    chk("mid_rst_valid", valid_o, 0); chk("mid_rst_ready", ready_o, 0);
    chk("mid_rst_err", {err_o, err_code_o}, 0); chk("mid_rst_count", count_o, 0);
    reset_n = 1; ready_i = 1;
    #1 chk("post_rst_ready", ready_o, 1);
    send(7'h6f, 1, 0, 0, 0, 0, 32'hfffffffe, 1, model(7'h6f, 1, 0, 0, 0, 0, 32'hfffffffe));
    chk("post_rst_valid", valid_o, 1);
    drain();
    chk("post_rst_count", count_o, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
